key_command_decoder: RTL

KEY_COMMAND_DECODER -- requirements
Module: key_command_decoder

---
 rtl/key_command_decoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/key_command_decoder.sv
// PS/2 scan-byte parser turning arrow / grip / home keys into one-cycle command
// pulses, with typematic-style auto-repeat of the most recently pressed direction.
module key_command_decoder #(
  parameter int REPEAT_DELAY   = 6250000,
  parameter int REPEAT_PERIOD  = 1250000,
  parameter int PREFIX_TIMEOUT = 125000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan,
  input  logic       check,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic [2:0] held
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(PREFIX_TIMEOUT + 1);

  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_ONE    = RW'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;

  logic [2:0] key;
  logic       is_ext, is_brk, is_prefix, is_dir;
  logic       do_make, do_brk, new_dir, expire;

  function automatic logic [2:0] map_code(input logic ext, input logic [7:0] b);
    map_code = 3'd0;
    if (ext) begin
      case (b)
        8'h75:   map_code = 3'd1;
        8'h72:   map_code = 3'd2;
        8'h6B:   map_code = 3'd3;
        8'h74:   map_code = 3'd4;
        default: map_code = 3'd0;
      endcase
    end else begin
      case (b)
        8'h1D:   map_code = 3'd1;
        8'h1B:   map_code = 3'd2;
        8'h1C:   map_code = 3'd3;
        8'h23:   map_code = 3'd4;
        8'h29:   map_code = 3'd5;
        8'h2D:   map_code = 3'd6;
        default: map_code = 3'd0;
      endcase
    end
  endfunction

  // Prefix bytes only steer the parser from IDLE/EXT; after F0 every byte is a key.
  always_comb begin
    is_ext    = (state == EXT) || (state == EXT_BRK);
    is_brk    = (state == BRK) || (state == EXT_BRK);
    is_prefix = ((state == IDLE) || (state == EXT)) && ((scan == B_EXT) || (scan == B_BRK));
    key       = map_code(is_ext, scan);
    is_dir    = (key != 3'd0) && (key <= 3'd4);
    do_make   = check && !is_prefix && !is_brk && (key != 3'd0);
    do_brk    = check && is_brk && is_dir && (key == held);
    new_dir   = do_make && is_dir && (key != held);
    expire    = (held != 3'd0) && (rcnt == R_ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rcnt      <= '0;
      tcnt      <= '0;
      held      <= 3'd0;
      cmd       <= 3'd0;
      cmd_valid <= 1'b0;
    end else begin
      cmd       <= 3'd0;
      cmd_valid <= 1'b0;

      if (check) begin
        tcnt <= '0;
        case (state)
          IDLE:    state <= (scan == B_EXT) ? EXT : (scan == B_BRK) ? BRK : IDLE;
          EXT:     state <= (scan == B_EXT) ? EXT : (scan == B_BRK) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == T_LAST) begin
          state <= IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + T_ONE;
        end
      end

      // A fresh direction overrides any expiry; grip/home replace the expiry pulse only.
      if (do_brk) begin
        held <= 3'd0;
        rcnt <= '0;
      end else if (new_dir) begin
        held      <= key;
        rcnt      <= R_DELAY;
        cmd       <= key;
        cmd_valid <= 1'b1;
      end else begin
        if (expire) begin
          rcnt      <= R_PERIOD;
          cmd       <= held;
          cmd_valid <= 1'b1;
        end else if (held != 3'd0) begin
          rcnt <= rcnt - R_ONE;
        end
        if (do_make && !is_dir) begin
          cmd       <= key;
          cmd_valid <= 1'b1;
        end
      end
    end
  end

endmodule
